button_event_decoder: RTL and testbench

Consumes the clean, single-bit output of the debounce filter and converts held/released levels into one-cycle user-input events: press, release, short click, double click and long press, plus a running press count. Sits directly downstream of the debounce stage and feeds board-level control logic (LED/mode/counter demo tops), so those consumers never handle raw level timing themselves.

---
 rtl/button_event_pkg.sv | 19 +
 rtl/button_event_decoder_if.sv | 24 ++
 rtl/button_event_decoder_edge_detect.sv | 25 ++
 rtl/button_event_decoder.sv | 117 +++++++++++
 tb/tb_button_event_decoder.sv | 138 +++++++++++++
 5 files changed

// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared state encoding and default thresholds for the button event decoder.
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  localparam int DEFAULT_LONG_PRESS_CYCLES   = 250000;
  localparam int DEFAULT_DOUBLE_CLICK_WINDOW = 100000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// rtl/button_event_decoder_if.sv - debounced level in, event pulses and press count out.
interface button_event_decoder_if;

  logic       i_Debounced;
  logic       o_Press_Pulse;
  logic       o_Release_Pulse;
  logic       o_Short_Click;
  logic       o_Double_Click;
  logic       o_Long_Press;
  logic [7:0] o_Press_Count;

  modport master (
    output i_Debounced,
    input  o_Press_Pulse, o_Release_Pulse, o_Short_Click, o_Double_Click,
           o_Long_Press, o_Press_Count
  );

  modport slave (
    input  i_Debounced,
    output o_Press_Pulse, o_Release_Pulse, o_Short_Click, o_Double_Click,
           o_Long_Press, o_Press_Count
  );

endinterface

// File: rtl/button_event_decoder_edge_detect.sv
// rtl/button_event_decoder_edge_detect.sv - previous-level register with combinational rise/fall strobes.
module edge_detect #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev <= RESET_VALUE;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - turns a debounced button level into press/release/click/long-press pulses.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES   = DEFAULT_LONG_PRESS_CYCLES,
  parameter int DOUBLE_CLICK_WINDOW = DEFAULT_DOUBLE_CLICK_WINDOW
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  button_event_decoder_if.slave bus
);

  localparam int CW = $clog2(max_int(LONG_PRESS_CYCLES, DOUBLE_CLICK_WINDOW) + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LONG_LIMIT   = cnt_t'(LONG_PRESS_CYCLES);
  localparam cnt_t WINDOW_LIMIT = cnt_t'(DOUBLE_CLICK_WINDOW);
  localparam cnt_t CNT_ONE      = cnt_t'(1);

  state_t state, state_next;
  cnt_t   count, count_next, count_inc;
  logic   rise, fall;
  logic   short_next, double_next, long_next;

  // Reset value 1 makes a button held through reset look already pressed.
  edge_detect #(.RESET_VALUE(1'b1)) u_edge (
    .clk    (i_Clk),
    .resetn (i_Rst_L),
    .level  (bus.i_Debounced),
    .rise   (rise),
    .fall   (fall)
  );

  assign count_inc = count + CNT_ONE;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state               <= IDLE;
      count               <= '0;
      bus.o_Press_Pulse   <= 1'b0;
      bus.o_Release_Pulse <= 1'b0;
      bus.o_Short_Click   <= 1'b0;
      bus.o_Double_Click  <= 1'b0;
      bus.o_Long_Press    <= 1'b0;
      bus.o_Press_Count   <= 8'd0;
    end else begin
      state               <= state_next;
      count               <= count_next;
      bus.o_Press_Pulse   <= rise;
      bus.o_Release_Pulse <= fall;
      bus.o_Short_Click   <= short_next;
      bus.o_Double_Click  <= double_next;
      bus.o_Long_Press    <= long_next;
      if (rise) begin
        bus.o_Press_Count <= bus.o_Press_Count + 8'd1;
      end
    end
  end

  // Edges are tested before thresholds so a rise or fall on the expiry edge wins.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = PRESSED;
          count_next = CNT_ONE;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_next = WAIT_SECOND;
          count_next = CNT_ONE;
        end else if (count_inc == LONG_LIMIT) begin
          state_next = LONG_HELD;
        end else begin
          count_next = count_inc;
        end
      end
      LONG_HELD: begin
        if (fall) state_next = IDLE;
      end
      WAIT_SECOND: begin
        if (rise) begin
          state_next = SECOND_PRESSED;
        end else if (count_inc == WINDOW_LIMIT) begin
          state_next = IDLE;
        end else begin
          count_next = count_inc;
        end
      end
      SECOND_PRESSED: begin
        if (fall) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_comb begin
    short_next  = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
    case (state)
      PRESSED:     long_next   = ~fall & (count_inc == LONG_LIMIT);
      WAIT_SECOND: begin
        double_next = rise;
        short_next  = ~rise & (count_inc == WINDOW_LIMIT);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed checks of button_event_decoder with LONG=8, WINDOW=6.
module tb_button_event_decoder;

  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] P = 5'b10000;
  localparam logic [4:0] R = 5'b01000;
  localparam logic [4:0] S = 5'b00100;
  localparam logic [4:0] D = 5'b00010;
  localparam logic [4:0] L = 5'b00001;

  logic clk = 1'b0;
  logic rst_l;
  int   total = 0;
  int   bad = 0;

  button_event_decoder_if bus_if ();

  button_event_decoder #(
    .LONG_PRESS_CYCLES   (8),
    .DOUBLE_CLICK_WINDOW (6)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_l),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // Pulse vector order: press, release, short, double, long.
  task automatic step(input logic d, input logic [4:0] exp, input string tag);
    logic [4:0] obs;
    bus_if.i_Debounced = d;
    @(posedge clk);
    #1;
    obs = {bus_if.o_Press_Pulse, bus_if.o_Release_Pulse, bus_if.o_Short_Click,
           bus_if.o_Double_Click, bus_if.o_Long_Press};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: pulses=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic steps(input logic d, input int n, input string tag);
    for (int i = 0; i < n; i++) step(d, N, tag);
  endtask

  task automatic check_count(input logic [7:0] exp, input string tag);
    total++;
    assert (bus_if.o_Press_Count === exp) else begin
      bad++;
      $error("FAIL %s: count=%0d expected=%0d", tag, bus_if.o_Press_Count, exp);
    end
  endtask

  initial begin
    bus_if.i_Debounced = 1'b0;
    rst_l = 1'b0;
    step(0, N, "reset_a");
    step(0, N, "reset_b");
    check_count(8'd0, "reset_count");
    rst_l = 1'b1;
    step(0, R, "post_reset_fall");

    step(1, P, "t1_press");
    steps(1, 2, "t1_hold");
    step(0, R, "t1_release");
    steps(0, 4, "t1_window");
    step(0, S, "t1_short");
    step(0, N, "t1_after");
    check_count(8'd1, "t1_count");

    step(1, P, "t2_press");
    steps(1, 6, "t2_hold");
    step(1, L, "t2_long");
    steps(1, 2, "t2_held");
    step(0, R, "t2_release");
    steps(0, 7, "t2_no_click");
    check_count(8'd2, "t2_count");

    step(1, P, "t3_press1");
    step(1, N, "t3_hold1");
    step(0, R, "t3_rel1");
    steps(0, 2, "t3_gap");
    step(1, P | D, "t3_double");
    step(1, N, "t3_hold2");
    step(0, R, "t3_rel2");
    steps(0, 7, "t3_no_short");
    check_count(8'd4, "t3_count");

    step(1, P, "t4_press1");
    step(0, R, "t4_rel1");
    steps(0, 4, "t4_gap");
    step(1, P | D, "t4_double_edge");
    steps(1, 9, "t4_no_long_second");
    step(0, R, "t4_rel2");
    steps(0, 7, "t4_idle");
    step(1, P, "t4_press3");
    steps(1, 6, "t4_hold3");
    step(0, R, "t4_fall_at_long");
    steps(0, 4, "t4_window");
    step(0, S, "t4_short");
    check_count(8'd7, "t4_count");

    bus_if.i_Debounced = 1'b1;
    rst_l = 1'b0;
    step(1, N, "t5_reset_held_a");
    step(1, N, "t5_reset_held_b");
    rst_l = 1'b1;
    steps(1, 10, "t5_held_after_reset");
    check_count(8'd0, "t5_count_held");
    step(0, R, "t5_release");
    steps(0, 7, "t5_idle");
    step(1, P, "t5_repress");
    check_count(8'd1, "t5_count_repress");
    step(0, R, "t5_rel");
    steps(0, 2, "t5_wait");
    rst_l = 1'b0;
    step(0, N, "t5_reset_in_wait");
    rst_l = 1'b1;
    step(0, R, "t5_post_reset_fall");
    steps(0, 8, "t5_no_short");
    check_count(8'd0, "t5_count_reset");

    for (int g = 1; g <= 257; g++) begin
      step(1, P, "t6_press");
      step(0, R, "t6_release");
      steps(0, 4, "t6_window");
      step(0, S, "t6_short");
      if (g == 256) check_count(8'd0, "t6_count_256");
    end
    check_count(8'd1, "t6_count_257");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
